ldpc_ber_monitor: RTL and testbench

LDPC_BER_MONITOR -- requirements
Module: ldpc_ber_monitor

---
 rtl/ldpc_ber_monitor_if.sv | 41 ++++
 rtl/ldpc_ber_monitor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ldpc_ber_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_ber_monitor_if.sv
// ----------------------------------------------------------------------------
// ldpc_ber_monitor_if
// Groups the reference-word handshake and the decoder hard-bit stream that
// feed the LDPC bit-error-rate monitor.
//
//   ref_valid  reference word offered (source -> monitor)
//   ref_data   reference word, LANES soft-bit fields of SBW bits; lane 0 is
//              the most significant field, its MSB is the hard decision
//   ref_ready  monitor can accept a reference word (monitor -> source)
//   hb_vlid    decoder hard-bit word valid (decoder -> monitor)
//   hardbit    decoded hard bits, lane n on bit n
//
// Modports: master = stimulus side (reference source + decoder),
//           slave  = the monitor.
// ----------------------------------------------------------------------------
interface ldpc_ber_monitor_if #(
  parameter int LANES = 16,
  parameter int SBW   = 3
);
  logic                   ref_valid;
  logic [LANES*SBW-1:0]   ref_data;
  logic                   ref_ready;
  logic                   hb_vlid;
  logic [LANES-1:0]       hardbit;

  modport master (
    output ref_valid,
    output ref_data,
    output hb_vlid,
    output hardbit,
    input  ref_ready
  );

  modport slave (
    input  ref_valid,
    input  ref_data,
    input  hb_vlid,
    input  hardbit,
    output ref_ready
  );
endinterface

// File: rtl/ldpc_ber_monitor.sv
// ----------------------------------------------------------------------------
// ldpc_ber_monitor
// Compares decoded LDPC hard bits against a buffered reference codeword and
// keeps per-block and running bit-error statistics.
//
// Reference words are queued in a small FIFO (only their hard decisions are
// stored). Each decoder word pops one reference word; the XOR mismatch is
// registered (stage 1) and its popcount accumulated (stage 2). The block
// boundary is tracked by a word index that advances only on pops.
//
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   clr            synchronous clear of FIFO, counters, flags, pipeline
//   bus            ldpc_ber_monitor_if.slave (reference + hard-bit streams)
//   blk_done       one-cycle pulse when a block completes
//   blk_err_cnt    bit errors in the last completed block
//   total_err      saturating bit-error count
//   blk_cnt        completed blocks (wrapping)
//   fail_cnt       blocks with errors (saturating)
//   underflow      sticky: decoder word arrived with the FIFO empty
//   first_err_loc  first error bit index of the last block
//
// Optional feature macro: BER_ERRLOC_EN enables first-error location capture;
// when undefined, first_err_loc is tied to 0.
// ----------------------------------------------------------------------------
module ldpc_ber_monitor #(
  parameter int LANES      = 16,
  parameter int SBW        = 3,
  parameter int BLOCK_BITS = 10240,
  parameter int DEPTH      = 8,
  localparam int BEW       = $clog2(BLOCK_BITS + 1),
  localparam int LOCW      = $clog2(BLOCK_BITS)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  clr,
  ldpc_ber_monitor_if.slave     bus,
  output logic                  blk_done,
  output logic [BEW-1:0]        blk_err_cnt,
  output logic [31:0]           total_err,
  output logic [15:0]           blk_cnt,
  output logic [15:0]           fail_cnt,
  output logic                  underflow,
  output logic [LOCW-1:0]       first_err_loc
);

  localparam int WORDS  = BLOCK_BITS / LANES;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int PCW    = $clog2(LANES + 1);

  // Hard decision of each lane: MSB of its soft-bit field, lane 0 at the top.
  logic [LANES-1:0] ref_hb;
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_ref_hb
      assign ref_hb[gi] = bus.ref_data[(LANES-1-gi)*SBW + SBW-1];
    end
  endgenerate

  // ---------------- reference FIFO ----------------
  logic [LANES-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill;
  logic             fifo_empty, fifo_full;
  logic             push, pop, uflow_evt;
  logic [LANES-1:0] rd_hb;

  // Occupancy comes from registered pointers only, so a word pushed this
  // cycle cannot be popped until the next one.
  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (AW+1)'(DEPTH));
  assign push       = bus.ref_valid && !fifo_full;
  assign pop        = bus.hb_vlid && !fifo_empty;
  assign uflow_evt  = bus.hb_vlid && fifo_empty;
  assign bus.ref_ready = !fifo_full;
  assign rd_hb      = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push && !clr) begin
      mem[wr_ptr_q[AW-1:0]] <= ref_hb;
    end
  end

  // ---------------- pipeline and statistics ----------------
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              widx_last;
  logic              s1_valid_q, s1_valid_d;
  logic [LANES-1:0]  s1_mism_q, s1_mism_d;
  logic              s1_last_q, s1_last_d;
  logic [BEW-1:0]    blk_acc_q, blk_acc_d;
  logic              blk_done_q, blk_done_d;
  logic [BEW-1:0]    blk_err_cnt_q, blk_err_cnt_d;
  logic [31:0]       total_err_q, total_err_d;
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic [15:0]       fail_cnt_q, fail_cnt_d;
  logic              underflow_q, underflow_d;
  logic [PCW-1:0]    pc;
  logic [BEW-1:0]    blk_sum;
  logic [32:0]       total_sum;

  assign widx_last = (widx_q == WIDX_W'(WORDS - 1));

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PCW'(s1_mism_q[i]);
    end
  end

  assign blk_sum   = blk_acc_q + BEW'(pc);
  assign total_sum = {1'b0, total_err_q} + 33'(pc);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    widx_d        = widx_q;
    s1_valid_d    = pop;
    s1_mism_d     = bus.hardbit ^ rd_hb;
    s1_last_d     = pop && widx_last;
    blk_acc_d     = blk_acc_q;
    blk_done_d    = 1'b0;
    blk_err_cnt_d = blk_err_cnt_q;
    total_err_d   = total_err_q;
    blk_cnt_d     = blk_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    underflow_d   = underflow_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      widx_d   = widx_last ? '0 : widx_q + WIDX_W'(1);
    end
    if (uflow_evt) underflow_d = 1'b1;

    if (s1_valid_q) begin
      total_err_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
      if (s1_last_q) begin
        blk_done_d    = 1'b1;
        blk_err_cnt_d = blk_sum;
        blk_cnt_d     = blk_cnt_q + 16'd1;
        if ((blk_sum != '0) && (fail_cnt_q != 16'hFFFF)) begin
          fail_cnt_d = fail_cnt_q + 16'd1;
        end
        blk_acc_d = '0;
      end else begin
        blk_acc_d = blk_sum;
      end
    end

    if (clr) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      widx_d        = '0;
      s1_valid_d    = 1'b0;
      s1_mism_d     = '0;
      s1_last_d     = 1'b0;
      blk_acc_d     = '0;
      blk_done_d    = 1'b0;
      blk_err_cnt_d = '0;
      total_err_d   = '0;
      blk_cnt_d     = '0;
      fail_cnt_d    = '0;
      underflow_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      widx_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_mism_q     <= '0;
      s1_last_q     <= 1'b0;
      blk_acc_q     <= '0;
      blk_done_q    <= 1'b0;
      blk_err_cnt_q <= '0;
      total_err_q   <= '0;
      blk_cnt_q     <= '0;
      fail_cnt_q    <= '0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      widx_q        <= widx_d;
      s1_valid_q    <= s1_valid_d;
      s1_mism_q     <= s1_mism_d;
      s1_last_q     <= s1_last_d;
      blk_acc_q     <= blk_acc_d;
      blk_done_q    <= blk_done_d;
      blk_err_cnt_q <= blk_err_cnt_d;
      total_err_q   <= total_err_d;
      blk_cnt_q     <= blk_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      underflow_q   <= underflow_d;
    end
  end

  assign blk_done    = blk_done_q;
  assign blk_err_cnt = blk_err_cnt_q;
  assign total_err   = total_err_q;
  assign blk_cnt     = blk_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign underflow   = underflow_q;

`ifdef BER_ERRLOC_EN
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WIDX_W-1:0] s1_widx_q;
  logic              loc_found_q, loc_found_d;
  logic [LOCW-1:0]   loc_q, loc_d;
  logic [LOCW-1:0]   first_err_loc_q, first_err_loc_d;
  logic [LW-1:0]     low_lane;
  logic [LOCW-1:0]   new_loc;
  logic              found_now;
  logic [LOCW-1:0]   loc_now;

  // Lowest mismatching lane: scan downward so the last hit is the lowest.
  always_comb begin
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (s1_mism_q[i]) low_lane = LW'(i);
    end
  end

  assign new_loc   = LOCW'(s1_widx_q) * LOCW'(LANES) + LOCW'(low_lane);
  assign found_now = loc_found_q || (s1_mism_q != '0);
  assign loc_now   = loc_found_q ? loc_q : new_loc;

  always_comb begin
    loc_found_d     = loc_found_q;
    loc_d           = loc_q;
    first_err_loc_d = first_err_loc_q;
    if (s1_valid_q) begin
      if (s1_last_q) begin
        // An error-free block reports all ones.
        first_err_loc_d = found_now ? loc_now : '1;
        loc_found_d     = 1'b0;
        loc_d           = '0;
      end else begin
        loc_found_d = found_now;
        loc_d       = loc_now;
      end
    end
    if (clr) begin
      loc_found_d     = 1'b0;
      loc_d           = '0;
      first_err_loc_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_widx_q       <= '0;
      loc_found_q     <= 1'b0;
      loc_q           <= '0;
      first_err_loc_q <= '0;
    end else begin
      s1_widx_q       <= clr ? '0 : widx_q;
      loc_found_q     <= loc_found_d;
      loc_q           <= loc_d;
      first_err_loc_q <= first_err_loc_d;
    end
  end

  assign first_err_loc = first_err_loc_q;
`else
  assign first_err_loc = '0;
`endif

endmodule

// File: tb/tb_ldpc_ber_monitor.sv
module tb_ldpc_ber_monitor;
  localparam int LANES      = 16;
  localparam int SBW        = 3;
  localparam int BLOCK_BITS = 10240;
  localparam int DEPTH      = 8;
  localparam int WORDS      = BLOCK_BITS / LANES;
  localparam int BEW        = $clog2(BLOCK_BITS + 1);
  localparam int LOCW       = $clog2(BLOCK_BITS);

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic clr = 1'b0;
  logic            blk_done;
  logic [BEW-1:0]  blk_err_cnt;
  logic [31:0]     total_err;
  logic [15:0]     blk_cnt;
  logic [15:0]     fail_cnt;
  logic            underflow;
  logic [LOCW-1:0] first_err_loc;

  always #5 CLK = ~CLK;

  ldpc_ber_monitor_if #(.LANES(LANES), .SBW(SBW)) bus ();

  ldpc_ber_monitor #(
    .LANES(LANES), .SBW(SBW), .BLOCK_BITS(BLOCK_BITS), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .clr(clr),
    .bus(bus),
    .blk_done(blk_done),
    .blk_err_cnt(blk_err_cnt),
    .total_err(total_err),
    .blk_cnt(blk_cnt),
    .fail_cnt(fail_cnt),
    .underflow(underflow),
    .first_err_loc(first_err_loc)
  );

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  always @(posedge CLK) cycle_no <= cycle_no + 1;

  typedef struct {
    int     cyc;
    int     blk_err;
    int     blk_cnt;
    int     fail_cnt;
    longint total;
    int     loc;
  } exp_t;

  exp_t exp_q[$];
  int   done_log[$];

  // Reference model state
  logic [LANES-1:0] mq[$];
  int     m_widx = 0;
  int     m_blk_err = 0;
  int     m_blk_cnt = 0;
  int     m_fail = 0;
  longint m_total = 0;
  bit     m_loc_found = 0;
  int     m_loc = 0;
  logic [LANES-1:0] err_mask [2][WORDS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every blk_done must match the oldest expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (RESET_N) begin
      if (blk_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_blk_done", 64'(blk_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cycle_no), 64'(e.cyc));
          chk("blk_err_cnt", 64'(blk_err_cnt), 64'(e.blk_err));
          chk("blk_cnt", 64'(blk_cnt), 64'(e.blk_cnt));
          chk("fail_cnt", 64'(fail_cnt), 64'(e.fail_cnt));
          chk("total_err", 64'(total_err), 64'(e.total));
          chk("first_err_loc", 64'(first_err_loc), 64'(e.loc));
          done_log.push_back(int'(blk_err_cnt));
        end
      end else if (exp_q.size() > 0 && cycle_no >= exp_q[0].cyc) begin
        chk("missed_blk_done", 64'(blk_done), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_widx = 0; m_blk_err = 0; m_blk_cnt = 0; m_fail = 0;
    m_total = 0; m_loc_found = 0; m_loc = 0;
  endtask

  // One clock of stimulus; updates the model and schedules expected results.
  task automatic step(input bit pv, input bit hv, input logic [LANES-1:0] hb);
    logic [LANES-1:0]     phb;
    logic [LANES*SBW-1:0] rd;
    logic [LANES-1:0]     ref_w;
    logic [LANES-1:0]     mism;
    bit   acc_push, do_pop;
    int   cnt;
    exp_t e;
    phb = LANES'($urandom);
    rd  = (LANES*SBW)'({$urandom, $urandom});
    for (int n = 0; n < LANES; n++) rd[(LANES-1-n)*SBW + SBW-1] = phb[n];
    chk("ref_ready", 64'(bus.ref_ready), 64'(mq.size() < DEPTH));
    bus.ref_valid = pv;
    bus.ref_data  = rd;
    bus.hb_vlid   = hv;
    bus.hardbit   = hb;
    acc_push = pv && (mq.size() < DEPTH);
    do_pop   = hv && (mq.size() > 0);
    if (do_pop) begin
      ref_w = mq.pop_front();
      mism  = hb ^ ref_w;
      cnt   = $countones(mism);
      m_blk_err += cnt;
      m_total += cnt;
      if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
      if (!m_loc_found && mism != '0) begin
        m_loc_found = 1;
        for (int i = 0; i < LANES; i++) begin
          if (mism[i]) begin
            m_loc = m_widx * LANES + i;
            break;
          end
        end
      end
      if (m_widx == WORDS - 1) begin
        m_blk_cnt = (m_blk_cnt + 1) % 65536;
        if (m_blk_err != 0 && m_fail < 65535) m_fail++;
        e.cyc      = cycle_no + 2;
        e.blk_err  = m_blk_err;
        e.blk_cnt  = m_blk_cnt;
        e.fail_cnt = m_fail;
        e.total    = m_total;
`ifdef BER_ERRLOC_EN
        e.loc      = m_loc_found ? m_loc : (1 << LOCW) - 1;
`else
        e.loc      = 0;
`endif
        exp_q.push_back(e);
        m_blk_err = 0;
        m_loc_found = 0;
        m_widx = 0;
      end else begin
        m_widx++;
      end
    end
    if (acc_push) mq.push_back(phb);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  // Push n_push reference words and pop n_pop decoder words, streaming.
  task automatic stream(input int n_push, input int n_pop);
    int pushed = 0;
    int popped = 0;
    int iter = 0;
    bit pv, hv;
    logic [LANES-1:0] hb;
    while (popped < n_pop && iter < 4 * (n_push + DEPTH) + 100) begin
      pv = (pushed < n_push) && (mq.size() < DEPTH);
      hv = mq.size() > 0;
      hb = hv ? (mq[0] ^ err_mask[m_blk_cnt & 1][m_widx]) : '0;
      step(pv, hv, hb);
      if (pv) pushed++;
      if (hv) popped++;
      iter++;
    end
    bus.ref_valid = 1'b0;
    bus.hb_vlid   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_blk_done"}, 64'(blk_done), 64'd0);
    chk({tag, "_blk_err_cnt"}, 64'(blk_err_cnt), 64'd0);
    chk({tag, "_total_err"}, 64'(total_err), 64'd0);
    chk({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
    chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'd0);
    chk({tag, "_underflow"}, 64'(underflow), 64'd0);
    chk({tag, "_first_err_loc"}, 64'(first_err_loc), 64'd0);
    chk({tag, "_ref_ready"}, 64'(bus.ref_ready), 64'd1);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_clear();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b0, 1'b0, '0);
    clr = 1'b0;
    model_clear();
    check_all_zero("clr");
  endtask

  task automatic clear_masks();
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < WORDS; w++) err_mask[b][w] = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ref_valid = 1'b0;
    bus.ref_data  = '0;
    bus.hb_vlid   = 1'b0;
    bus.hardbit   = '0;
    clear_masks();
    @(posedge CLK);
    #1;
    do_reset();

    // Clean block: one blk_done, no errors.
    done_log.delete();
    stream(WORDS, WORDS);
    idle(4);
    chk("t044_done_count", 64'(done_log.size()), 64'd1);
    chk("t044_blk_cnt", 64'(blk_cnt), 64'd1);
    chk("t044_blk_err", 64'(blk_err_cnt), 64'd0);
    chk("t044_fail_cnt", 64'(fail_cnt), 64'd0);

    // Two flipped bits: lane 0 of word 5, lane 15 of word 639.
    do_clr();
    done_log.delete();
    err_mask[0][5]   = 16'h0001;
    err_mask[0][639] = 16'h8000;
    stream(WORDS, WORDS);
    idle(4);
    chk("t045_blk_err", 64'(blk_err_cnt), 64'd2);
    chk("t045_total_err", 64'(total_err), 64'd2);
    chk("t045_fail_cnt", 64'(fail_cnt), 64'd1);
    chk("t045_blk_cnt", 64'(blk_cnt), 64'd1);
`ifdef BER_ERRLOC_EN
    chk("t045_first_err_loc", 64'(first_err_loc), 64'd80);
`else
    chk("t045_first_err_loc", 64'(first_err_loc), 64'd0);
`endif
    clear_masks();

    // Underflow is sticky and does not advance the word index.
    do_clr();
    step(1'b0, 1'b1, 16'hA5A5);
    idle(1);
    chk("t046_underflow", 64'(underflow), 64'd1);
    done_log.delete();
    stream(WORDS, WORDS);
    idle(4);
    chk("t046_done_count", 64'(done_log.size()), 64'd1);
    chk("t046_blk_cnt", 64'(blk_cnt), 64'd1);
    chk("t046_underflow_sticky", 64'(underflow), 64'd1);

    // Fill the FIFO, then release one slot.
    do_clr();
    repeat (DEPTH) step(1'b1, 1'b0, '0);
    bus.ref_valid = 1'b0;
    chk("t047_full_ready", 64'(bus.ref_ready), 64'd0);
    step(1'b0, 1'b1, mq[0]);
    bus.hb_vlid = 1'b0;
    chk("t047_after_pop_ready", 64'(bus.ref_ready), 64'd1);

    // Reset in the middle of a block discards it.
    stream(300 - DEPTH, 300 - 1);
    idle(2);
    do_reset();
    done_log.delete();
    stream(WORDS, WORDS);
    idle(4);
    chk("t048_done_count", 64'(done_log.size()), 64'd1);
    chk("t048_blk_cnt", 64'(blk_cnt), 64'd1);
    chk("t048_blk_err", 64'(blk_err_cnt), 64'd0);

    // Back-to-back blocks with 3 then 0 errors.
    do_clr();
    done_log.delete();
    err_mask[0][0]   = 16'h0003;
    err_mask[0][100] = 16'h0400;
    stream(2 * WORDS, 2 * WORDS);
    idle(4);
    chk("t049_done_count", 64'(done_log.size()), 64'd2);
    chk("t049_blk0_err", 64'(done_log.size() > 0 ? done_log[0] : -1), 64'd3);
    chk("t049_blk1_err", 64'(done_log.size() > 1 ? done_log[1] : -1), 64'd0);
    chk("t049_total_err", 64'(total_err), 64'd3);
    chk("t049_fail_cnt", 64'(fail_cnt), 64'd1);
    chk("t049_blk_cnt", 64'(blk_cnt), 64'd2);
`ifdef BER_ERRLOC_EN
    chk("t049_first_err_loc", 64'(first_err_loc), 64'((1 << LOCW) - 1));
`else
    chk("t049_first_err_loc", 64'(first_err_loc), 64'd0);
`endif
    chk("final_pending_done", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
